// File: rtl/mac_sched_pkg.sv
// Shared types and widths for the 3x3 conv MAC sequencer.
package mac_sched_pkg;

    localparam int unsigned DIN_W = 128;
    localparam int unsigned WGT_W = 72;
    localparam int unsigned ACC_W = 20;
    localparam int unsigned OUT_W = 4 * ACC_W;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StRun,
        StDrain,
        StDone
    } stateT;

endpackage

// File: rtl/mac_sched_fifo.sv
// Synchronous result FIFO; head reads as zero while empty, push+pop honoured when full.
module mac_sched_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 81
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [Width-1:0]             wdata,
    input  logic                         pop,
    output logic [Width-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(Depth+1)-1:0]   count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  rdPtrQ, wrPtrQ;
    logic [CntW-1:0]  cntQ;
    logic             doPush, doPop;

    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full   = (cntQ == CntW'(Depth));
    assign empty  = (cntQ == '0);
    assign count  = cntQ;
    assign doPop  = pop && !empty;
    // A pop frees the slot the push lands in, so full does not block it.
    assign doPush = push && (!full || doPop);
    assign rdata  = empty ? '0 : mem[rdPtrQ];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtrQ] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtrQ <= '0;
            wrPtrQ <= '0;
            cntQ   <= '0;
        end else begin
            if (doPush) wrPtrQ <= nextPtr(wrPtrQ);
            if (doPop)  rdPtrQ <= nextPtr(rdPtrQ);
            cntQ <= cntQ + CntW'(doPush) - CntW'(doPop);
        end
    end

endmodule

// File: rtl/mac_sched.sv
// Credit-based job sequencer: loads weights, issues windows in raster order, buffers results.
module mac_sched
    import mac_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TW-1:0]      cfg_tiles_x,
    input  logic [TW-1:0]      cfg_tiles_y,
    input  logic               wgt_valid,
    output logic               wgt_ready,
    input  logic [WGT_W-1:0]   wgt_data,
    input  logic               win_valid,
    output logic               win_ready,
    input  logic [DIN_W-1:0]   win_data,
    output logic               mac_vld,
    output logic [DIN_W-1:0]   mac_din,
    output logic [WGT_W-1:0]   mac_weight,
    input  logic               mac_vld_o,
    input  logic [OUT_W-1:0]   mac_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned SumW = CntW + 1;

    stateT             stateQ, stateD;
    logic [TW-1:0]     tilesXQ, tilesYQ, tileXQ, tileYQ;
    logic [2*TW-1:0]   resultCntQ, totalTiles;
    logic [CntW-1:0]   inFlightQ, fifoCnt;
    logic              errQ, macVldQ;
    logic [DIN_W-1:0]  macDinQ;
    logic [WGT_W-1:0]  macWeightQ;
    logic              fifoFull, fifoEmpty, fifoPop, winFire;
    logic              lastTileX, lastTileY, retOk, orphan, overflow, resLast;
    logic [OUT_W:0]    fifoRdata;

    assign totalTiles = (2*TW)'(tilesXQ) * (2*TW)'(tilesYQ);
    assign lastTileX  = (tileXQ == tilesXQ - TW'(1));
    assign lastTileY  = (tileYQ == tilesYQ - TW'(1));
    assign resLast    = (resultCntQ == totalTiles - (2*TW)'(1));

    assign wgt_ready  = (stateQ == StLoadW);
    // Credit: every accepted window must have a FIFO slot reserved for its result.
    assign win_ready  = (stateQ == StRun) &&
                        ((SumW'(inFlightQ) + SumW'(fifoCnt)) < SumW'(DEPTH));
    assign winFire    = win_valid && win_ready;
    assign retOk      = mac_vld_o && (inFlightQ != '0);
    assign orphan     = mac_vld_o && (inFlightQ == '0);
    assign out_valid  = !fifoEmpty;
    assign fifoPop    = out_valid && out_ready;
    assign overflow   = retOk && fifoFull && !fifoPop;

    assign out_data   = fifoRdata[OUT_W-1:0];
    assign out_last   = fifoRdata[OUT_W];
    assign busy       = (stateQ != StIdle);
    assign done       = (stateQ == StDone);
    assign err        = errQ;
    assign mac_vld    = macVldQ;
    assign mac_din    = macDinQ;
    assign mac_weight = macWeightQ;

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    stateD = (cfg_tiles_x == '0 || cfg_tiles_y == '0) ? StDone : StLoadW;
                end
            end
            StLoadW: if (wgt_valid) stateD = StRun;
            StRun:   if (winFire && lastTileX && lastTileY) stateD = StDrain;
            StDrain: if (inFlightQ == '0 && fifoEmpty) stateD = StDone;
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ     <= StIdle;
            tilesXQ    <= '0;
            tilesYQ    <= '0;
            tileXQ     <= '0;
            tileYQ     <= '0;
            resultCntQ <= '0;
            inFlightQ  <= '0;
            errQ       <= 1'b0;
            macVldQ    <= 1'b0;
            macDinQ    <= '0;
            macWeightQ <= '0;
        end else begin
            stateQ    <= stateD;
            macVldQ   <= winFire;
            inFlightQ <= inFlightQ + CntW'(winFire) - CntW'(retOk);
            if (winFire) begin
                macDinQ <= win_data;
                if (lastTileX) begin
                    tileXQ <= '0;
                    tileYQ <= tileYQ + TW'(1);
                end else begin
                    tileXQ <= tileXQ + TW'(1);
                end
            end
            if (retOk) resultCntQ <= resultCntQ + (2*TW)'(1);
            if (stateQ == StLoadW && wgt_valid) macWeightQ <= wgt_data;
            if (stateQ == StIdle && start) begin
                tilesXQ    <= cfg_tiles_x;
                tilesYQ    <= cfg_tiles_y;
                tileXQ     <= '0;
                tileYQ     <= '0;
                resultCntQ <= '0;
                errQ       <= 1'b0;
            end
            // A fresh protocol error wins over the clear from start.
            if (orphan || overflow) errQ <= 1'b1;
        end
    end

    mac_sched_fifo #(
        .Depth (DEPTH),
        .Width (OUT_W + 1)
    ) uFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (retOk),
        .wdata ({resLast, mac_out}),
        .pop   (fifoPop),
        .rdata (fifoRdata),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCnt)
    );

endmodule

// File: tb/tb_mac_sched.sv
// Randomized bench: fixed-latency MAC stand-in plus a conv/queue reference model.
module tb_mac_sched;

    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic         clk = 1'b0;
    logic         rst, start, wgt_valid, win_valid, out_ready, spur;
    logic [7:0]   cfg_tiles_x, cfg_tiles_y;
    logic [71:0]  wgt_data;
    logic [127:0] win_data;
    logic         wgt_ready, win_ready, mac_vld, out_valid, out_last, busy, done, err;
    logic [127:0] mac_din;
    logic [71:0]  mac_weight;
    logic [79:0]  out_data, macOut;
    logic         macVldO;

    logic         pv [LAT];
    logic [79:0]  pd [LAT];

    int checks = 0;
    int errors = 0;
    logic [80:0] expQ [$];
    logic [71:0] refW;
    int accTot, popTot, accJob, popJob, lastCnt, doneCnt, jobN;
    int wgtRdyCnt, winRdyCnt, outVldCnt;
    bit wgtTaken;

    always #5 clk = ~clk;

    mac_sched dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_tiles_x (cfg_tiles_x),
        .cfg_tiles_y (cfg_tiles_y),
        .wgt_valid   (wgt_valid),
        .wgt_ready   (wgt_ready),
        .wgt_data    (wgt_data),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_data    (win_data),
        .mac_vld     (mac_vld),
        .mac_din     (mac_din),
        .mac_weight  (mac_weight),
        .mac_vld_o   (macVldO),
        .mac_out     (macOut),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // 2x2 outputs of a 3x3 signed conv over a 4x4 window; lane = row*2 + col.
    function automatic logic [79:0] conv(input logic [127:0] px, input logic [71:0] w);
        logic [79:0] r;
        int acc;
        logic signed [7:0] a, b;
        r = '0;
        for (int oy = 0; oy < 2; oy++) begin
            for (int ox = 0; ox < 2; ox++) begin
                acc = 0;
                for (int ky = 0; ky < 3; ky++) begin
                    for (int kx = 0; kx < 3; kx++) begin
                        a = px[((oy + ky) * 4 + ox + kx) * 8 +: 8];
                        b = w[(ky * 3 + kx) * 8 +: 8];
                        acc += int'(a) * int'(b);
                    end
                end
                r[(oy * 2 + ox) * 20 +: 20] = acc[19:0];
            end
        end
        return r;
    endfunction

    task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // MAC stand-in: fixed latency, cleared by the shared reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= mac_vld;
            pd[0] <= conv(mac_din, mac_weight);
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign macVldO = pv[LAT-1] | spur;
    assign macOut  = pd[LAT-1];

    // Reference model: expected result per accepted window, checked at each pop.
    initial begin : monitor
        logic [80:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                expQ.delete();
                accTot = 0;
                popTot = 0;
            end else begin
                if (wgt_ready) wgtRdyCnt++;
                if (win_ready) winRdyCnt++;
                if (out_valid) outVldCnt++;
                if (done) doneCnt++;
                if (wgt_valid && wgt_ready) begin
                    refW = wgt_data;
                    wgtTaken = 1'b1;
                end
                if (win_valid && win_ready) begin
                    checkEq("credit", 128'((accTot - popTot) < DEPTH), 128'd1);
                    expQ.push_back({accJob == jobN - 1, conv(win_data, refW)});
                    accTot++;
                    accJob++;
                end
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        checkEq("unexpected_out", 128'(out_valid), 128'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkEq("out_data", 128'(out_data), 128'(e[79:0]));
                        checkEq("out_last", 128'(out_last), 128'(e[80]));
                    end
                    popTot++;
                    popJob++;
                    if (out_last) lastCnt++;
                end
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkEq({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        checkEq({tag, "_out_data"}, 128'(out_data), 128'd0);
        checkEq({tag, "_out_last"}, 128'(out_last), 128'd0);
        checkEq({tag, "_busy"}, 128'(busy), 128'd0);
        checkEq({tag, "_done"}, 128'(done), 128'd0);
        checkEq({tag, "_err"}, 128'(err), 128'd0);
        checkEq({tag, "_wgt_ready"}, 128'(wgt_ready), 128'd0);
        checkEq({tag, "_win_ready"}, 128'(win_ready), 128'd0);
        checkEq({tag, "_mac_vld"}, 128'(mac_vld), 128'd0);
        checkEq({tag, "_mac_din"}, mac_din, 128'd0);
        checkEq({tag, "_mac_weight"}, 128'(mac_weight), 128'd0);
    endtask

    task automatic startJob(input int tx, input int ty, input bit ones);
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        accJob = 0;
        popJob = 0;
        lastCnt = 0;
        doneCnt = 0;
        wgtTaken = 1'b0;
        jobN = tx * ty;
        cfg_tiles_x = 8'(tx);
        cfg_tiles_y = 8'(ty);
        wgt_valid = 1'b1;
        wgt_data = ones ? 72'h01_0101_0101_0101_0101 : r[71:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkEq("start_err_clear", 128'(err), 128'd0);
    endtask

    // rdyMode: 0 always ready, 1 random, 2 toggle every cycle.
    task automatic runJob(input int tx, input int ty, input bit ones, input bit winAlways,
                          input int rdyMode, input int stall);
        int n;
        n = tx * ty;
        startJob(tx, ty, ones);
        for (int cyc = 0; cyc < 3000 && doneCnt == 0; cyc++) begin
            if (wgtTaken) wgt_valid = 1'b0;
            win_valid = (ones || winAlways) ? 1'b1 : ($urandom_range(0, 3) != 0);
            win_data = ones ? {16{8'h01}} : {$urandom(), $urandom(), $urandom(), $urandom()};
            if (cyc < stall)       out_ready = 1'b0;
            else if (rdyMode == 0) out_ready = 1'b1;
            else if (rdyMode == 1) out_ready = 1'($urandom_range(0, 1));
            else                   out_ready = cyc[0];
            if (stall > 0 && cyc == stall) begin
                checkEq("stall_accepted", 128'(accJob), 128'((n < DEPTH) ? n : DEPTH));
                checkEq("stall_win_ready", 128'(win_ready), 128'd0);
            end
            @(posedge clk);
            #1;
        end
        win_valid = 1'b0;
        wgt_valid = 1'b0;
        checkEq("job_done", 128'(doneCnt), 128'd1);
        checkEq("job_busy", 128'(busy), 128'd0);
        checkEq("job_accepted", 128'(accJob), 128'(n));
        checkEq("job_pops", 128'(popJob), 128'(n));
        checkEq("job_last", 128'(lastCnt), 128'd1);
        checkEq("job_err", 128'(err), 128'd0);
        checkEq("job_queue", 128'(expQ.size()), 128'd0);
        @(posedge clk);
        #1;
        checkEq("job_done_once", 128'(doneCnt), 128'd1);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        spur = 1'b0;
        cfg_tiles_x = '0;
        cfg_tiles_y = '0;
        wgt_valid = 1'b0;
        wgt_data = '0;
        win_valid = 1'b0;
        win_data = '0;
        out_ready = 1'b0;
        refW = '0;
        accJob = 0;
        popJob = 0;
        lastCnt = 0;
        doneCnt = 0;
        jobN = 0;
        wgtRdyCnt = 0;
        winRdyCnt = 0;
        outVldCnt = 0;
        wgtTaken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 2x2 of all-ones: every lane 9, last on the fourth result only.
        runJob(2, 2, 1'b1, 1'b1, 0, 0);
        // Stalled output: credit caps acceptance at the FIFO depth.
        runJob(3, 1, 1'b0, 1'b0, 1, 50);
        runJob(4, 2, 1'b0, 1'b0, 1, 50);
        // Six back-to-back windows against a toggling consumer.
        runJob(3, 2, 1'b0, 1'b1, 2, 0);

        // Zero-size job: done next cycle, no handshakes, no output.
        wgtRdyCnt = 0;
        winRdyCnt = 0;
        outVldCnt = 0;
        doneCnt = 0;
        cfg_tiles_x = 8'd0;
        cfg_tiles_y = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkEq("zero_done", 128'(done), 128'd1);
        checkEq("zero_busy", 128'(busy), 128'd1);
        @(posedge clk);
        #1;
        checkEq("zero_done_drop", 128'(done), 128'd0);
        checkEq("zero_idle", 128'(busy), 128'd0);
        repeat (4) @(posedge clk);
        #1;
        checkEq("zero_done_cnt", 128'(doneCnt), 128'd1);
        checkEq("zero_wgt_ready", 128'(wgtRdyCnt), 128'd0);
        checkEq("zero_win_ready", 128'(winRdyCnt), 128'd0);
        checkEq("zero_out_valid", 128'(outVldCnt), 128'd0);

        // Orphan MAC result while idle: sticky err, nothing buffered.
        outVldCnt = 0;
        spur = 1'b1;
        @(posedge clk);
        #1;
        spur = 1'b0;
        checkEq("spur_err", 128'(err), 128'd1);
        repeat (4) @(posedge clk);
        #1;
        checkEq("spur_err_held", 128'(err), 128'd1);
        checkEq("spur_no_out", 128'(outVldCnt), 128'd0);
        runJob(1, 1, 1'b0, 1'b1, 0, 0);

        // Randomized jobs.
        for (int j = 0; j < 6; j++) begin
            runJob($urandom_range(1, 4), $urandom_range(1, 3), 1'b0, 1'b0,
                   $urandom_range(0, 2), ($urandom_range(0, 2) == 0) ? 20 : 0);
        end

        // Reset mid-RUN with two results sitting in the FIFO.
        startJob(4, 1, 1'b1);
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 200 && accJob < 2; cyc++) begin
            if (wgtTaken) wgt_valid = 1'b0;
            win_valid = 1'b1;
            win_data = {16{8'h01}};
            @(posedge clk);
            #1;
        end
        win_valid = 1'b0;
        wgt_valid = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        checkEq("midrun_buffered", 128'(out_valid), 128'd1);
        checkEq("midrun_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("midrun_rst");
        rst = 1'b0;
        outVldCnt = 0;
        repeat (LAT + 3) @(posedge clk);
        #1;
        checkEq("post_rst_no_out", 128'(outVldCnt), 128'd0);
        checkEq("post_rst_err", 128'(err), 128'd0);
        runJob(2, 1, 1'b0, 1'b0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
